// File: rtl/restoring_division_pkg.sv
// Shared definitions for the restoring-division request sequencer: FSM encoding,
// operand/result widths and the divider watchdog limit.
package restoring_division_pkg;

  localparam int DATA_W = 4;
  localparam int REM_W  = 5;
  localparam int WDOG_W = 4;

  localparam logic [WDOG_W-1:0] WDOG_LIMIT = 4'd15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/restoring_division_sequencer.sv
// Request/response sequencer in front of an external restoring divider, with a done
// watchdog. Define DIV_ZERO_BYPASS_EN to answer divide-by-zero requests locally.
module restoring_division_sequencer
  import restoring_division_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_dividend,
  input  logic [DATA_W-1:0] req_divisor,
  output logic              div_start,
  output logic [DATA_W-1:0] div_dividend,
  output logic [DATA_W-1:0] div_divisor,
  input  logic              div_done,
  input  logic [DATA_W-1:0] div_quotient,
  input  logic [REM_W-1:0]  div_remainder,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_quotient,
  output logic [REM_W-1:0]  rsp_remainder,
  output logic              rsp_div_by_zero,
  output logic              rsp_timeout
);

  seq_state_t        state, state_next;
  logic [WDOG_W-1:0] wdog;
  logic              accept, capture, expire, bypass_hit;

`ifdef DIV_ZERO_BYPASS_EN
  assign bypass_hit = (req_divisor == '0);
`else
  assign bypass_hit = 1'b0;
`endif

  assign req_ready = (state == IDLE);
  assign div_start = (state == ISSUE);
  assign rsp_valid = (state == RESP);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // div_done wins over the watchdog on the last permitted WAIT cycle
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    capture    = 1'b0;
    expire     = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          accept     = 1'b1;
          state_next = bypass_hit ? RESP : ISSUE;
        end
      end
      ISSUE: state_next = WAIT;
      WAIT: begin
        if (div_done) begin
          capture    = 1'b1;
          state_next = RESP;
        end else if (wdog == WDOG_LIMIT - 4'd1) begin
          expire     = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog <= '0;
    end else if (state == ISSUE) begin
      wdog <= '0;
    end else if (state == WAIT && !div_done) begin
      wdog <= wdog + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_dividend  <= '0;
      div_divisor   <= '0;
      rsp_quotient  <= '0;
      rsp_remainder <= '0;
      rsp_timeout   <= 1'b0;
    end else begin
      if (accept) begin
        div_dividend <= req_dividend;
        div_divisor  <= req_divisor;
        rsp_timeout  <= 1'b0;
`ifdef DIV_ZERO_BYPASS_EN
        if (bypass_hit) begin
          rsp_quotient  <= '1;
          rsp_remainder <= {1'b0, req_dividend};
        end
`endif
      end
      if (capture) begin
        rsp_quotient  <= div_quotient;
        rsp_remainder <= div_remainder;
      end
      if (expire) begin
        rsp_quotient  <= '0;
        rsp_remainder <= '0;
        rsp_timeout   <= 1'b1;
      end
    end
  end

`ifdef DIV_ZERO_BYPASS_EN
  always_ff @(posedge clk) begin
    if (rst)         rsp_div_by_zero <= 1'b0;
    else if (accept) rsp_div_by_zero <= bypass_hit;
  end
`else
  assign rsp_div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_restoring_division_sequencer.sv
// Bench for restoring_division_sequencer: behavioural divider, transaction-level
// expectation model checked every cycle, directed corner cases, then random traffic.
module tb_restoring_division_sequencer;

  logic       clk, rst, req_valid, req_ready;
  logic [3:0] req_dividend, req_divisor;
  logic       div_start;
  logic [3:0] div_dividend, div_divisor;
  logic       div_done;
  logic [3:0] div_quotient;
  logic [4:0] div_remainder;
  logic       rsp_valid, rsp_ready;
  logic [3:0] rsp_quotient;
  logic [4:0] rsp_remainder;
  logic       rsp_div_by_zero, rsp_timeout;

  logic rsp_ready_dir, bp_ready, bp_en, stray_en, mon_en;
  int   lat, acc_lat, n_cmp, n_bad, cyc, n_start;

  typedef struct {
    logic [3:0] q;
    logic [4:0] r;
    logic       dbz;
    logic       to;
    logic       bypass;
    int         delay;
  } exp_t;

  exp_t       cur;
  bit         pending = 0;
  int         acc_cyc, rsp_cyc;
  logic [3:0] last_a, last_b;

  assign rsp_ready = bp_en ? bp_ready : rsp_ready_dir;

  restoring_division_sequencer dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_done(div_done), .div_quotient(div_quotient), .div_remainder(div_remainder),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
    .rsp_div_by_zero(rsp_div_by_zero), .rsp_timeout(rsp_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected response of one request, from the sequencer's rules and the divider's latency
  function automatic exp_t predict(input logic [3:0] a, input logic [3:0] b, input int l);
    exp_t e;
    e.dbz = 1'b0; e.to = 1'b0; e.bypass = 1'b0;
`ifdef DIV_ZERO_BYPASS_EN
    if (b == 4'd0) begin
      e.q = 4'hF; e.r = {1'b0, a}; e.dbz = 1'b1; e.bypass = 1'b1; e.delay = 1;
      return e;
    end
`endif
    if (l < 1 || l > 15) begin
      e.q = 4'd0; e.r = 5'd0; e.to = 1'b1; e.delay = 17;
    end else begin
      e.q     = (b == 4'd0) ? 4'hF : a / b;
      e.r     = (b == 4'd0) ? {1'b0, a} : {1'b0, a % b};
      e.delay = l + 2;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Divider: done pulses acc_lat cycles after div_start (0 = never); strays when idle
  logic [3:0] op_a, op_b;
  bit         busy_d = 0;
  int         cnt;
  always @(posedge clk) begin
    #2;
    div_done      = 1'b0;
    div_quotient  = 4'($urandom_range(0, 15));
    div_remainder = 5'($urandom_range(0, 31));
    if (rst) begin
      busy_d = 0;
    end else begin
      if (busy_d) begin
        cnt--;
        if (cnt == 0) begin
          busy_d        = 0;
          div_done      = 1'b1;
          div_quotient  = (op_b == 4'd0) ? 4'hF : op_a / op_b;
          div_remainder = (op_b == 4'd0) ? {1'b0, op_a} : {1'b0, op_a % op_b};
        end
      end else if (stray_en && $urandom_range(0, 3) == 0) begin
        div_done = 1'b1;
      end
      if (div_start === 1'b1) begin
        busy_d = 1;
        cnt    = (acc_lat == 0) ? 100000 : acc_lat;
        op_a   = div_dividend;
        op_b   = div_divisor;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    bp_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic monitor();
    bit exp_ready, exp_valid, exp_start;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        cyc++;
        if (div_start === 1'b1) n_start++;
        exp_ready = !pending;
        exp_valid = pending && (cyc >= rsp_cyc);
        exp_start = pending && !cur.bypass && (cyc == acc_cyc + 1);
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
        chk("div_start", 32'(div_start), 32'(exp_start));
        chk("div_dividend", 32'(div_dividend), 32'(last_a));
        chk("div_divisor", 32'(div_divisor), 32'(last_b));
        if (exp_valid) begin
          chk("rsp_quotient", 32'(rsp_quotient), 32'(cur.q));
          chk("rsp_remainder", 32'(rsp_remainder), 32'(cur.r));
          chk("rsp_div_by_zero", 32'(rsp_div_by_zero), 32'(cur.dbz));
          chk("rsp_timeout", 32'(rsp_timeout), 32'(cur.to));
        end
        if (rst) begin
          pending = 0; last_a = 4'd0; last_b = 4'd0;
        end else begin
          if (exp_valid && rsp_ready) pending = 0;
          if (exp_ready && req_valid) begin
            pending = 1;
            acc_cyc = cyc;
            acc_lat = lat;
            cur     = predict(req_dividend, req_divisor, lat);
            rsp_cyc = cyc + cur.delay;
            last_a  = req_dividend;
            last_b  = req_divisor;
          end
        end
      end
    end
  endtask

  task automatic send(input logic [3:0] a, input logic [3:0] b, input int l);
    bit took = 0;
    @(posedge clk); #1;
    lat = l; req_dividend = a; req_divisor = b; req_valid = 1'b1;
    for (int i = 0; i < 120 && !took; i++) begin
      @(negedge clk);
      if (req_ready === 1'b1) took = 1;
    end
    chk("accepted", 32'(took), 1);
    @(posedge clk); #1;
    req_valid    = 1'b0;
    req_dividend = 4'($urandom_range(0, 15));
    req_divisor  = 4'($urandom_range(0, 15));
  endtask

  task automatic wait_rsp();
    bit seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) seen = 1;
    end
    chk("rsp_seen", 32'(seen), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit: got expired expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "time limit");
  end

  initial begin
    exp_t e;
    int   s0, l;
    logic [3:0] a, b;
    rst = 1'b1; req_valid = 1'b0; req_dividend = 4'd0; req_divisor = 4'd0;
    rsp_ready_dir = 1'b1; bp_en = 1'b0; stray_en = 1'b0; mon_en = 1'b0;
    lat = 1; acc_lat = 1; n_cmp = 0; n_bad = 0; cyc = 0; n_start = 0;
    last_a = 4'd0; last_b = 4'd0; acc_cyc = 0; rsp_cyc = 0;
    cur = predict(4'd0, 4'd1, 1);
    fork
      monitor();
    join_none

    @(posedge clk); #1 mon_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_div_start", 32'(div_start), 0);
    chk("rst_div_dividend", 32'(div_dividend), 0);
    chk("rst_div_divisor", 32'(div_divisor), 0);
    chk("rst_rsp_quotient", 32'(rsp_quotient), 0);
    chk("rst_rsp_remainder", 32'(rsp_remainder), 0);
    chk("rst_rsp_dbz", 32'(rsp_div_by_zero), 0);
    chk("rst_rsp_timeout", 32'(rsp_timeout), 0);
    @(posedge clk); #1 rst = 1'b0;

    e = predict(4'd13, 4'd3, 3);
    chk("model_13_3_q", 32'(e.q), 4);
    chk("model_13_3_r", 32'(e.r), 1);
    chk("model_13_3_delay", 32'(e.delay), 5);
    e = predict(4'd2, 4'd5, 16);
    chk("model_wd_to", 32'(e.to), 1);
    chk("model_wd_delay", 32'(e.delay), 17);

    s0 = n_start;
    send(4'd13, 4'd3, 3);
    wait_rsp();
    chk("d13_3_q", 32'(rsp_quotient), 4);
    chk("d13_3_r", 32'(rsp_remainder), 1);
    chk("d13_3_dbz", 32'(rsp_div_by_zero), 0);
    chk("d13_3_to", 32'(rsp_timeout), 0);
    chk("d13_3_starts", 32'(n_start - s0), 1);

    s0 = n_start;
    send(4'd7, 4'd0, 2);
    wait_rsp();
    chk("d7_0_q", 32'(rsp_quotient), 32'hF);
    chk("d7_0_r", 32'(rsp_remainder), 32'h07);
`ifdef DIV_ZERO_BYPASS_EN
    chk("d7_0_dbz", 32'(rsp_div_by_zero), 1);
    chk("d7_0_starts", 32'(n_start - s0), 0);
`else
    chk("d7_0_dbz", 32'(rsp_div_by_zero), 0);
    chk("d7_0_starts", 32'(n_start - s0), 1);
`endif

    @(posedge clk); #1 rsp_ready_dir = 1'b0;
    send(4'd15, 4'd2, 4);
    wait_rsp();
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("hold_valid", 32'(rsp_valid), 1);
      chk("hold_q", 32'(rsp_quotient), 7);
      chk("hold_r", 32'(rsp_remainder), 1);
      chk("hold_req_ready", 32'(req_ready), 0);
    end
    @(posedge clk); #1 rsp_ready_dir = 1'b1;

    send(4'd11, 4'd5, 0);
    wait_rsp();
    chk("stuck_to", 32'(rsp_timeout), 1);
    chk("stuck_q", 32'(rsp_quotient), 0);
    chk("stuck_r", 32'(rsp_remainder), 0);

    send(4'd14, 4'd3, 15);
    wait_rsp();
    chk("lat15_q", 32'(rsp_quotient), 4);
    chk("lat15_r", 32'(rsp_remainder), 2);
    chk("lat15_to", 32'(rsp_timeout), 0);

    send(4'd14, 4'd3, 16);
    wait_rsp();
    chk("lat16_to", 32'(rsp_timeout), 1);
    chk("lat16_q", 32'(rsp_quotient), 0);

    send(4'd6, 4'd2, 10);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_wait_req_ready", 32'(req_ready), 1);
    chk("rst_wait_rsp_valid", 32'(rsp_valid), 0);
    send(4'd9, 4'd4, 2);
    wait_rsp();
    chk("d9_4_q", 32'(rsp_quotient), 2);
    chk("d9_4_r", 32'(rsp_remainder), 1);

    bp_en = 1'b1; stray_en = 1'b1;
    for (int t = 0; t < 150; t++) begin
      a = 4'($urandom_range(0, 15));
      b = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      l = $urandom_range(0, 19);
      if (l > 17) l = $urandom_range(1, 4);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      send(a, b, l);
    end
    begin
      bit drained = 0;
      for (int i = 0; i < 200 && !drained; i++) begin
        @(negedge clk);
        if (!pending) drained = 1;
      end
      chk("drained", 32'(drained), 1);
    end
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/restoring_division_sequencer.md
RESTORING_DIVISION_SEQUENCER -- requirements
Module: restoring_division_sequencer

Interface
REQ-001 SHALL have ports: clk  input  1  single clock, all logic on posedge.
REQ-002 SHALL have ports: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have ports: req_valid  input  1  upstream request valid.
REQ-004 SHALL have ports: req_ready  output  1  sequencer can accept a request.
REQ-005 SHALL have ports: req_dividend  input  4  unsigned dividend.
REQ-006 SHALL have ports: req_divisor  input  4  unsigned divisor.
REQ-007 SHALL have ports: div_start  output  1  one-cycle start pulse to the divider.
REQ-008 SHALL have ports: div_dividend  output  4  and div_divisor  output  4  registered operands to the divider.
REQ-009 SHALL have ports: div_done  input  1  divider completion.
REQ-010 SHALL have ports: div_quotient  input  4  and div_remainder  input  5  divider results.
REQ-011 SHALL have ports: rsp_valid  output  1  response valid.
REQ-012 SHALL have ports: rsp_ready  input  1  downstream accepts response.
REQ-013 SHALL have ports: rsp_quotient  output  4, rsp_remainder  output  5, rsp_div_by_zero  output  1, rsp_timeout  output  1.

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-015 SHALL assert req_ready only in IDLE; a request is accepted when req_valid && req_ready.
REQ-016 SHALL, on acceptance, register both operands and go IDLE->ISSUE.
REQ-017 SHALL hold div_dividend/div_divisor stable from ISSUE until the next acceptance.
REQ-018 SHALL assert div_start for exactly the one ISSUE cycle, then go ISSUE->WAIT.
REQ-019 SHALL, in WAIT, on the first cycle div_done=1, capture div_quotient/div_remainder into the response registers and go WAIT->RESP; div_done outside WAIT SHALL be ignored.
REQ-020 SHALL run a 4-bit watchdog, cleared on entry to WAIT and incremented each WAIT cycle without div_done.
REQ-021 SHALL, when the watchdog reaches 15 without div_done, go WAIT->RESP with rsp_timeout=1, rsp_quotient=0, rsp_remainder=0.
REQ-022 SHALL assert rsp_valid only in RESP and keep all rsp_* outputs stable while rsp_valid && !rsp_ready.
REQ-023 SHALL go RESP->IDLE on rsp_valid && rsp_ready; a new request SHALL NOT be accepted in that same cycle.
REQ-024 SHALL give a latency of (cycles to div_done after div_start)+2 from acceptance to rsp_valid.
REQ-025 SHALL clear rsp_div_by_zero and rsp_timeout on every acceptance.

Reset
REQ-026 SHALL, on rst=1 in any state including mid-WAIT, go to IDLE at the next edge and discard any in-flight request.
REQ-027 SHALL reset outputs to: req_ready=1 (IDLE), div_start=0, div_dividend=0, div_divisor=0, rsp_valid=0, rsp_quotient=0, rsp_remainder=0, rsp_div_by_zero=0, rsp_timeout=0, and watchdog=0.

Configuration
REQ-028 SHALL support macro DIV_ZERO_BYPASS_EN.
REQ-029 SHALL, with DIV_ZERO_BYPASS_EN defined, handle an accepted request with divisor 0 by going IDLE->RESP directly, with no div_start, rsp_quotient=4'hF, rsp_remainder={1'b0,dividend}, and rsp_div_by_zero=1.
REQ-030 SHALL, without DIV_ZERO_BYPASS_EN, forward divisor-0 requests to the divider like any other and tie rsp_div_by_zero to 0.

Structure
REQ-031 SHALL take the FSM state encoding, the watchdog limit (15), and the operand/result widths (4/5) from a shared restoring_division package.
REQ-032 SHALL be a single module with no sub-module; the divider is instantiated beside it at top level.

Verification
REQ-033 SHALL cover 13/3 with divider attached and rsp_ready=1 -> one div_start pulse, then rsp_quotient=4, rsp_remainder=1, flags 0.
REQ-034 SHALL cover 7/0 with DIV_ZERO_BYPASS_EN -> no div_start, rsp_valid 1 cycle after acceptance, quotient F, remainder 07, div_by_zero=1.
REQ-035 SHALL cover 15/2 with rsp_ready low for 5 cycles -> rsp_valid held, quotient 7 and remainder 1 stable, req_ready=0 throughout.
REQ-036 SHALL cover div_done stuck at 0 -> rsp_timeout=1 after 15 WAIT cycles, quotient 0, remainder 0.
REQ-037 SHALL cover rst pulsed in WAIT -> IDLE next cycle, rsp_valid never asserted, and a following 9/4 request returns quotient 2, remainder 1.
